// File: rtl/mdio_slave.sv
// mdio_slave: clause-22 MDIO responder with a clk-domain FSM sampling a synchronized mdc.
// Define MDIO_SLAVE_BROADCAST_EN to also accept write frames addressed to PHYAD 0.
module mdio_slave #(
  parameter logic [4:0] PHY_ADDR     = 5'h00,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_req,
  output logic [4:0]  rd_addr,
  input  logic [15:0] rd_data
);
  localparam int CW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [CW-1:0] PL = CW'(PREAMBLE_LEN);
  typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, DATA, IGNORE} state_t;
  state_t state_q, state_d;
  logic [1:0] mdc_sync_q, mdc_sync_d, mdio_sync_q, mdio_sync_d;
  logic mdc_prev_q, mdc_prev_d;
  logic [CW-1:0] pre_cnt_q, pre_cnt_d;
  logic [4:0] fpos_q, fpos_d, regad_q, regad_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [15:0] sr_q, sr_d, wr_data_q, wr_data_d;
  logic is_rd_q, is_rd_d, ld_q, ld_d, rd_req_q, rd_req_d, wr_valid_q, wr_valid_d;
  logic mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
  logic rise, fall, b, hit, drv;
  logic [4:0] ad;
  assign mdio_o   = mdio_o_q;
  assign mdio_t   = mdio_t_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  always_comb begin
    mdc_sync_d  = {mdc_sync_q[0], mdc};
    mdio_sync_d = {mdio_sync_q[0], mdio_i};
    mdc_prev_d  = mdc_sync_q[1];
    rise = mdc_sync_q[1] & ~mdc_prev_q;
    fall = ~mdc_sync_q[1] & mdc_prev_q;
    b    = mdio_sync_q[1];
    ad   = {sr_q[3:0], b};
`ifdef MDIO_SLAVE_BROADCAST_EN
    hit = (ad == PHY_ADDR) || (ad == 5'h00 && !is_rd_q);
`else
    hit = (ad == PHY_ADDR);
`endif
    // fpos_q is the frame index (0..31) of the next bit to be sampled
    drv        = is_rd_q && (state_q == TA || state_q == DATA);
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    fpos_d     = fpos_q;
    regad_d    = regad_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    sr_d       = ld_q ? rd_data : sr_q;
    is_rd_d    = is_rd_q;
    ld_d       = rd_req_q;
    rd_req_d   = 1'b0;
    wr_valid_d = 1'b0;
    mdio_o_d   = mdio_o_q;
    mdio_t_d   = mdio_t_q;
    if (rise) begin
      if (!drv) sr_d = {sr_q[14:0], b};
      if (state_q != IDLE) fpos_d = fpos_q + 5'd1;
      case (state_q)
        IDLE: begin
          pre_cnt_d = b ? ((pre_cnt_q == PL) ? PL : pre_cnt_q + CW'(1)) : '0;
          if (!b && pre_cnt_q == PL) begin
            state_d = ST;
            fpos_d  = 5'd1;
          end
        end
        ST: state_d = b ? OP : IDLE;
        OP: if (fpos_q == 5'd3) begin
          is_rd_d = sr_q[0] & ~b;
          state_d = (sr_q[0] ^ b) ? PHYAD : IGNORE;
        end
        PHYAD: if (fpos_q == 5'd8) state_d = hit ? REGAD : IGNORE;
        REGAD: if (fpos_q == 5'd13) begin
          state_d = TA;
          regad_d = ad;
          if (is_rd_q) begin
            rd_addr_d = ad;
            rd_req_d  = 1'b1;
          end
        end
        TA: if (fpos_q == 5'd15) state_d = DATA;
        DATA: if (fpos_q == 5'd31) begin
          state_d = IDLE;
          if (!is_rd_q) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = regad_q;
            wr_data_d  = {sr_q[14:0], b};
          end
        end
        IGNORE: if (fpos_q == 5'd31) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // read turnaround: the pad stays released for the first TA bit, then 0, then D15..D0
    if (fall) begin
      mdio_t_d = !(is_rd_q && ((state_q == TA && fpos_q == 5'd15) || state_q == DATA));
      mdio_o_d = (is_rd_q && state_q == DATA) ? sr_q[15] : 1'b0;
      if (is_rd_q && state_q == DATA) sr_d = {sr_q[14:0], 1'b0};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      pre_cnt_q   <= '0;
      fpos_q      <= '0;
      regad_q     <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sr_q        <= '0;
      is_rd_q     <= 1'b0;
      ld_q        <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_valid_q  <= 1'b0;
      mdio_o_q    <= 1'b0;
      mdio_t_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      mdc_sync_q  <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      mdc_prev_q  <= mdc_prev_d;
      pre_cnt_q   <= pre_cnt_d;
      fpos_q      <= fpos_d;
      regad_q     <= regad_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      sr_q        <= sr_d;
      is_rd_q     <= is_rd_d;
      ld_q        <= ld_d;
      rd_req_q    <= rd_req_d;
      wr_valid_q  <= wr_valid_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
    end
  end
endmodule

// File: tb/tb_mdio_slave.sv
// tb_mdio_slave: directed MDIO master driving frames into mdio_slave with PHY_ADDR=1.
module tb_mdio_slave;
  logic clk = 1'b0, rst_n = 1'b1, mdc = 1'b0;
  logic mdio_i, mdio_o, mdio_t, wr_valid, rd_req;
  logic [4:0] wr_addr, rd_addr, rd_addr_cap = 5'h0;
  logic [15:0] wr_data, rd_data = 16'h0;
  logic m_drv = 1'b1, m_en = 1'b1;
  int vecs = 0, errs = 0, wr_cnt = 0, rd_cnt = 0, tlow_cnt = 0;
  int w0, r0, t0;
  logic [15:0] q;
  logic ta1, ta2;
  always #5 clk = ~clk;
  // open-drain style line: slave when driving, else master, else pull-up
  assign mdio_i = !mdio_t ? mdio_o : (m_en ? m_drv : 1'b1);
  mdio_slave #(.PHY_ADDR(5'h01), .PREAMBLE_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always @(posedge clk) begin
    if (wr_valid) wr_cnt <= wr_cnt + 1;
    if (rd_req) begin
      rd_cnt      <= rd_cnt + 1;
      rd_addr_cap <= rd_addr;
    end
    if (!mdio_t) tlow_cnt <= tlow_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic bit_io(input logic v, output logic s);
    m_drv = v;
    #80 mdc = 1'b1;
    s = mdio_i;
    #80 mdc = 1'b0;
  endtask
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] d, input int rst_bit,
                       output logic [15:0] qo, output logic t1, output logic t2);
    logic s;
    logic [31:0] hdr;
    qo = 16'h0;
    t1 = 1'b0;
    t2 = 1'b0;
    hdr = {2'b01, op, pa, ra, 2'b10, d};
    for (int i = 0; i < pre; i++) bit_io(1'b1, s);
    for (int i = 31; i >= 0; i--) begin
      if (op == 2'b10 && i <= 17) m_en = 1'b0;
      if (op == 2'b10 && i == rst_bit) begin
        #40 chk("drive_before_rst", 32'(mdio_t), 32'h0);
        rst_n = 1'b0;
        #1 chk("t_async_rst", 32'(mdio_t), 32'h1);
        chk("o_async_rst", 32'(mdio_o), 32'h0);
        #30 rst_n = 1'b1;
        m_en = 1'b1;
        return;
      end
      bit_io(hdr[i], s);
      if (i == 17) t1 = s;
      else if (i == 16) t2 = s;
      else if (i < 16) qo[i] = s;
    end
    m_en = 1'b1;
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #30;
    chk("rst_mdio_t", 32'(mdio_t), 32'h1);
    chk("rst_mdio_o", 32'(mdio_o), 32'h0);
    chk("rst_wr_valid", 32'(wr_valid), 32'h0);
    chk("rst_rd_req", 32'(rd_req), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_rd_addr", 32'(rd_addr), 32'h0);
    #20 rst_n = 1'b1;
    #50;
    // basic write
    w0 = wr_cnt; t0 = tlow_cnt;
    frame(32, 2'b01, 5'h01, 5'h17, 16'h0022, -1, q, ta1, ta2);
    #200;
    chk("wr1_pulses", wr_cnt - w0, 32'h1);
    chk("wr1_addr", 32'(wr_addr), 32'h17);
    chk("wr1_data", 32'(wr_data), 32'h0022);
    chk("wr1_t_low", tlow_cnt - t0, 32'h0);
    // read, host returns 0x1234
    rd_data = 16'h1234;
    r0 = rd_cnt; w0 = wr_cnt;
    frame(32, 2'b10, 5'h01, 5'h02, 16'h0, -1, q, ta1, ta2);
    #200;
    chk("rd_pulses", rd_cnt - r0, 32'h1);
    chk("rd_addr", 32'(rd_addr_cap), 32'h02);
    chk("rd_ta1_released", 32'(ta1), 32'h1);
    chk("rd_ta2_zero", 32'(ta2), 32'h0);
    chk("rd_data", 32'(q), 32'h1234);
    chk("rd_t_after", 32'(mdio_t), 32'h1);
    chk("rd_o_after", 32'(mdio_o), 32'h0);
    chk("rd_no_wr", wr_cnt - w0, 32'h0);
    // wrong PHY address
    w0 = wr_cnt; t0 = tlow_cnt;
    frame(32, 2'b01, 5'h05, 5'h03, 16'hDEAD, -1, q, ta1, ta2);
    #200;
    chk("badpa_pulses", wr_cnt - w0, 32'h0);
    chk("badpa_t_low", tlow_cnt - t0, 32'h0);
    chk("badpa_hold", 32'(wr_data), 32'h0022);
    w0 = wr_cnt;
    frame(32, 2'b01, 5'h01, 5'h03, 16'hBEEF, -1, q, ta1, ta2);
    #200;
    chk("after_bad_pulses", wr_cnt - w0, 32'h1);
    chk("after_bad_addr", 32'(wr_addr), 32'h03);
    chk("after_bad_data", 32'(wr_data), 32'hBEEF);
    // short and long preambles
    w0 = wr_cnt;
    frame(31, 2'b01, 5'h01, 5'h04, 16'h5A5A, -1, q, ta1, ta2);
    #200;
    chk("pre31_pulses", wr_cnt - w0, 32'h0);
    w0 = wr_cnt;
    frame(40, 2'b01, 5'h01, 5'h05, 16'h0F0F, -1, q, ta1, ta2);
    #200;
    chk("pre40_pulses", wr_cnt - w0, 32'h1);
    chk("pre40_data", 32'(wr_data), 32'h0F0F);
    // back-to-back without preamble
    w0 = wr_cnt;
    frame(32, 2'b01, 5'h01, 5'h06, 16'h1111, -1, q, ta1, ta2);
    frame(0, 2'b01, 5'h01, 5'h07, 16'h2222, -1, q, ta1, ta2);
    #200;
    chk("b2b_pulses", wr_cnt - w0, 32'h1);
    chk("b2b_addr", 32'(wr_addr), 32'h06);
    chk("b2b_data", 32'(wr_data), 32'h1111);
    // reset during read data bit D8
    rd_data = 16'hA5C3;
    w0 = wr_cnt;
    frame(32, 2'b10, 5'h01, 5'h09, 16'h0, 8, q, ta1, ta2);
    #100;
    chk("postrst_no_wr", wr_cnt - w0, 32'h0);
    chk("postrst_rd_addr", 32'(rd_addr), 32'h0);
    w0 = wr_cnt;
    frame(32, 2'b01, 5'h01, 5'h1A, 16'h3C3C, -1, q, ta1, ta2);
    #200;
    chk("postrst_wr_pulses", wr_cnt - w0, 32'h1);
    chk("postrst_wr_data", 32'(wr_data), 32'h3C3C);
    // write to broadcast address 0
    w0 = wr_cnt;
    frame(32, 2'b01, 5'h00, 5'h1B, 16'h7777, -1, q, ta1, ta2);
    #200;
`ifdef MDIO_SLAVE_BROADCAST_EN
    chk("bcast_pulses", wr_cnt - w0, 32'h1);
`else
    chk("bcast_pulses", wr_cnt - w0, 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mdio_slave.md
MDIO_SLAVE -- requirements
Module: mdio_slave

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'h00, the PHY address this responder answers to.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 32, the number of consecutive MDIO ones required before a start.
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic is in this domain.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port mdc, input, 1: management clock from the master, asynchronous to clk.
REQ-006 SHALL have port mdio_i, input, 1: MDIO pad input.
REQ-007 SHALL have port mdio_o, output, 1: MDIO drive value.
REQ-008 SHALL have port mdio_t, output, 1: tristate enable; 1 releases the pad.
REQ-009 SHALL have port wr_valid, output, 1: one-clk pulse when a write frame completes.
REQ-010 SHALL have port wr_addr, output, 5: register address of the completed write.
REQ-011 SHALL have port wr_data, output, 16: data of the completed write.
REQ-012 SHALL have port rd_req, output, 1: one-clk pulse requesting read data.
REQ-013 SHALL have port rd_addr, output, 5: register address of the pending read.
REQ-014 SHALL have port rd_data, input, 16: read data returned by the host.

Function
REQ-015 SHALL pass mdc and mdio_i through 2-FF synchronizers, then detect rising and falling edges of the synchronized mdc.
REQ-016 SHALL sample synchronized mdio only on detected mdc rising edges, and SHALL change mdio_o and mdio_t only on detected falling edges.
REQ-017 SHALL implement these states: IDLE, ST, OP, PHYAD, REGAD, TA, DATA, IGNORE.
REQ-018 IDLE: the preamble counter increments per sampled 1, saturating at PREAMBLE_LEN; a sampled 0 with count < PREAMBLE_LEN clears it; a sampled 0 with count == PREAMBLE_LEN moves the FSM to ST.
REQ-019 ST: a sampled 1 moves to OP; a sampled 0 returns to IDLE with the counter cleared.
REQ-020 OP: 2 bits, MSB first; 01 = write, 10 = read; 00/11 moves to IGNORE.
REQ-021 PHYAD: 5 bits, MSB first; a mismatch with PHY_ADDR moves to IGNORE, otherwise REGAD.
REQ-022 REGAD: 5 bits; for a read, rd_addr is loaded and rd_req pulses on the clk after the last REGAD bit is sampled.
REQ-023 TA on write: 2 bits sampled, value not checked.
REQ-024 TA on read: mdio_t stays 1 at the falling edge after the first TA bit.
REQ-025 Read data latch: rd_data is latched into the shift register 2 clk after rd_req; the host SHALL hold rd_data valid from 1 clk after rd_req until that latch.
REQ-026 TA on read: mdio_o=0 and mdio_t=0 at the falling edge after TA bit 1 is sampled.
REQ-027 DATA on read: at each following falling edge, drive the next bit D15..D0; at the falling edge after D0 is sampled, set mdio_t=1 and go to IDLE.
REQ-028 DATA on write: sample 16 bits MSB first; after D0, update wr_addr/wr_data and pulse wr_valid for exactly 1 clk on the same cycle, then go to IDLE.
REQ-029 IGNORE: keep mdio_t=1 and count the remaining bits of a 64-bit frame (32 preamble + 32 frame), then go to IDLE with the counter cleared.
REQ-030 Every frame SHALL be preceded by a fresh preamble; back-to-back frames without preamble go to IDLE and are ignored.
REQ-031 Simultaneous mdc edge detections cannot occur; glitch-free mdc with half-period >= 4 clk is a usage requirement.
REQ-032 wr_addr/wr_data SHALL hold their last value between writes.

Reset
REQ-033 On rst_n low, the block SHALL immediately set: mdio_t=1, mdio_o=0, wr_valid=0, rd_req=0, wr_addr=0, wr_data=0, rd_addr=0, FSM=IDLE, counters=0, synchronizers=0.
REQ-034 Reset mid-frame SHALL release the bus asynchronously; the interrupted frame is discarded without wr_valid.

Configuration
REQ-035 With MDIO_SLAVE_BROADCAST_EN defined, write frames with PHYAD=5'h00 SHALL be accepted regardless of PHY_ADDR; read frames to 5'h00 are answered only if PHY_ADDR==0.
REQ-036 Without MDIO_SLAVE_BROADCAST_EN, only PHYAD==PHY_ADDR SHALL be accepted.

Verification
REQ-037 PHY_ADDR=1, write reg 0x17 data 0x0022 after 32-bit preamble -> one wr_valid pulse, wr_addr=0x17, wr_data=0x0022, mdio_t=1 throughout.
REQ-038 Read reg 0x02, host returns 0x1234 -> rd_req pulse with rd_addr=0x02; master samples TA bit 2 = 0 then 0x1234; mdio_t=1 after D0.
REQ-039 Write to PHYAD 0x05 (PHY_ADDR=1) -> no wr_valid, mdio_t=1; next valid frame is accepted.
REQ-040 Preamble of 31 ones then start -> ignored; preamble of 40 ones -> accepted.
REQ-041 rst_n asserted during read DATA bit D8 -> mdio_t=1 same cycle; after release, next valid write is accepted.
REQ-042 MDIO_SLAVE_BROADCAST_EN defined, write PHYAD 0 with PHY_ADDR=1 -> wr_valid; undefined -> no wr_valid.
